// File: rtl/cpu_types_pkg.sv
// Shared MIPS control types: opcode/funct encodings, ALU ops, multicycle FSM
// states and the mux-select codes driven towards the datapath.
package cpu_types_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;

  typedef enum logic [OP_W-1:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B,
    OP_HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [FUNCT_W-1:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_JR   = 6'h08,
    FN_ADD  = 6'h20,
    FN_ADDU = 6'h21,
    FN_SUB  = 6'h22,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_NOR  = 6'h27,
    FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_t;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;

  typedef enum logic [2:0] {
    MC_RST    = 3'd0,
    MC_FETCH  = 3'd1,
    MC_DECODE = 3'd2,
    MC_EXEC   = 3'd3,
    MC_MEM    = 3'd4,
    MC_WB     = 3'd5,
    MC_HALT   = 3'd6
  } mc_state_t;

  // Sequencing class of an instruction, as seen by the FSM
  typedef enum logic [3:0] {
    CL_NOP, CL_ALU, CL_LOAD, CL_STORE, CL_BEQ,
    CL_BNE, CL_J, CL_JAL, CL_JR, CL_HALT
  } iclass_t;

  localparam logic [1:0] PCSRC_NPC    = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REG    = 2'd3;

  localparam logic [1:0] WSEL_ALU  = 2'd0;
  localparam logic [1:0] WSEL_DMEM = 2'd1;
  localparam logic [1:0] WSEL_NPC  = 2'd2;
  localparam logic [1:0] WSEL_LUI  = 2'd3;

  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_R31 = 2'd2;

  typedef struct packed {
    iclass_t     iclass;
    aluop_t      alu_op;
    logic        alu_src;
    logic        ext_sel;
    logic [1:0]  reg_dst;
    logic [1:0]  wsel;
    logic        illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_decoder.sv
// Combinational MIPS decode: opcode/funct to static control fields and the
// instruction class used by the sequencing FSM.
module instr_decoder
  import cpu_types_pkg::*;
(
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  output ctrl_t              ctrl
);

  always_comb begin
    ctrl        = '0;
    ctrl.iclass = CL_ALU;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst = REGDST_RD;
        case (funct)
          FN_SLL:          ctrl.alu_op = ALU_SLL;
          FN_SRL:          ctrl.alu_op = ALU_SRL;
          FN_ADD, FN_ADDU: ctrl.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl.alu_op = ALU_SUB;
          FN_AND:          ctrl.alu_op = ALU_AND;
          FN_OR:           ctrl.alu_op = ALU_OR;
          FN_XOR:          ctrl.alu_op = ALU_XOR;
          FN_NOR:          ctrl.alu_op = ALU_NOR;
          FN_SLT:          ctrl.alu_op = ALU_SLT;
          FN_SLTU:         ctrl.alu_op = ALU_SLTU;
          FN_JR: begin
            ctrl.reg_dst = REGDST_RT;
            ctrl.iclass  = CL_JR;
          end
          default: begin
            ctrl.reg_dst = REGDST_RT;
            ctrl.iclass  = CL_NOP;
            ctrl.illegal = 1'b1;
          end
        endcase
      end
      OP_J:   ctrl.iclass = CL_J;
      OP_JAL: begin
        ctrl.iclass  = CL_JAL;
        ctrl.reg_dst = REGDST_R31;
        ctrl.wsel    = WSEL_NPC;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.iclass  = (opcode == OP_BEQ) ? CL_BEQ : CL_BNE;
        ctrl.alu_op  = ALU_SUB;
        ctrl.ext_sel = 1'b1;
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl.alu_op  = ALU_ADD;
        ctrl.alu_src = 1'b1;
        ctrl.ext_sel = 1'b1;
      end
      OP_SLTI, OP_SLTIU: begin
        ctrl.alu_op  = (opcode == OP_SLTI) ? ALU_SLT : ALU_SLTU;
        ctrl.alu_src = 1'b1;
        ctrl.ext_sel = 1'b1;
      end
      OP_ANDI: begin ctrl.alu_op = ALU_AND; ctrl.alu_src = 1'b1; end
      OP_ORI:  begin ctrl.alu_op = ALU_OR;  ctrl.alu_src = 1'b1; end
      OP_XORI: begin ctrl.alu_op = ALU_XOR; ctrl.alu_src = 1'b1; end
      OP_LUI: begin
        ctrl.alu_src = 1'b1;
        ctrl.wsel    = WSEL_LUI;
      end
      OP_LW, OP_SW: begin
        ctrl.iclass  = (opcode == OP_LW) ? CL_LOAD : CL_STORE;
        ctrl.alu_op  = ALU_ADD;
        ctrl.alu_src = 1'b1;
        ctrl.ext_sel = 1'b1;
        ctrl.wsel    = (opcode == OP_LW) ? WSEL_DMEM : WSEL_ALU;
      end
      OP_HALT: ctrl.iclass = CL_HALT;
      default: begin
        ctrl.iclass  = CL_NOP;
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control: sequences FETCH/DECODE/EXEC/MEM/WB, owns IR and the
// cache request handshake, and flags a hung memory bus via a wait counter.
module multicycle_control_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned WAIT_W   = 8,
  parameter int unsigned WAIT_MAX = 200
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] instr,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              zero,
  output logic              iREN,
  output logic              dREN,
  output logic              dWEN,
  output logic              pc_en,
  output logic [1:0]        pc_src,
  output logic              reg_wen,
  output logic [1:0]        reg_dst,
  output logic [1:0]        wsel,
  output aluop_t            alu_op,
  output logic              alu_src,
  output logic              ext_sel,
  output logic              halt,
  output logic              bus_err,
  output logic              illegal,
  output logic [2:0]        state_o
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  mc_state_t         state, state_n;
  logic [WORD_W-1:0] ir;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_miss, timeout;
  ctrl_t             ctrl;
  logic              unused_fields;

  instr_decoder u_dec (
    .opcode (ir[31:26]),
    .funct  (ir[5:0]),
    .ctrl   (ctrl)
  );

  assign unused_fields = ^ir[25:6];

  // The miss that would be the WAIT_MAX-th waited cycle is the one that times out
  assign wait_miss = ((state == MC_FETCH) && !ihit) || ((state == MC_MEM) && !dhit);
  assign timeout   = wait_miss && (wait_cnt >= WAIT_LAST);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= MC_RST;
      ir       <= '0;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      state <= state_n;
      if ((state == MC_FETCH) && ihit) ir <= instr;
      if (timeout) bus_err <= 1'b1;
      if (state_n != state) wait_cnt <= '0;
      else if (wait_miss && (wait_cnt != '1)) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    iREN    = 1'b0;
    dREN    = 1'b0;
    dWEN    = 1'b0;
    pc_en   = 1'b0;
    pc_src  = PCSRC_NPC;
    reg_wen = 1'b0;
    halt    = 1'b0;
    illegal = 1'b0;
    case (state)
      MC_RST:   state_n = MC_FETCH;
      MC_FETCH: begin
        iREN = 1'b1;
        if (ihit)         state_n = MC_DECODE;
        else if (timeout) state_n = MC_HALT;
      end
      MC_DECODE: begin
        illegal = ctrl.illegal;
        state_n = (ctrl.iclass == CL_HALT) ? MC_HALT : MC_EXEC;
      end
      MC_EXEC: begin
        state_n = MC_FETCH;
        case (ctrl.iclass)
          CL_BEQ: begin pc_en = 1'b1; pc_src = zero  ? PCSRC_BRANCH : PCSRC_NPC; end
          CL_BNE: begin pc_en = 1'b1; pc_src = !zero ? PCSRC_BRANCH : PCSRC_NPC; end
          CL_J:   begin pc_en = 1'b1; pc_src = PCSRC_JUMP; end
          CL_JR:  begin pc_en = 1'b1; pc_src = PCSRC_REG; end
          CL_NOP: pc_en = 1'b1;
          CL_LOAD, CL_STORE: state_n = MC_MEM;
          default: state_n = MC_WB;
        endcase
      end
      MC_MEM: begin
        dREN = (ctrl.iclass == CL_LOAD);
        dWEN = (ctrl.iclass == CL_STORE);
        if (dhit) begin
          if (ctrl.iclass == CL_LOAD) begin
            state_n = MC_WB;
          end else begin
            pc_en   = 1'b1;
            state_n = MC_FETCH;
          end
        end else if (timeout) begin
          state_n = MC_HALT;
        end
      end
      MC_WB: begin
        reg_wen = 1'b1;
        pc_en   = 1'b1;
        pc_src  = (ctrl.iclass == CL_JAL) ? PCSRC_JUMP : PCSRC_NPC;
        state_n = MC_FETCH;
      end
      MC_HALT: halt = 1'b1;
      default: state_n = MC_RST;
    endcase
  end

  always_comb begin
    alu_op  = ALU_SLL;
    alu_src = 1'b0;
    ext_sel = 1'b0;
    reg_dst = REGDST_RT;
    wsel    = WSEL_ALU;
    if ((state == MC_DECODE) || (state == MC_EXEC) || (state == MC_MEM) || (state == MC_WB)) begin
      alu_op  = ctrl.alu_op;
      alu_src = ctrl.alu_src;
      ext_sel = ctrl.ext_sel;
      reg_dst = ctrl.reg_dst;
      wsel    = ctrl.wsel;
    end
  end

  assign state_o = state;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle successor to the single-cycle decoder: same MIPS decode, with a sequencing FSM across FETCH/DECODE/EXEC/MEM/WB.
- Latches the instruction on ihit, drives the cache request handshake (iREN/dREN/dWEN against ihit/dhit), and pulses PC/register-file enables once per instruction.
- A parametrised wait-timeout counter flags a hung memory bus.
- Sits between the datapath and the caches, replacing the combinational control unit in the multicycle datapath.

Parameters:
WORD_W, 32, instruction width; opcode/field slicing is fixed at MIPS positions for WORD_W=32.
WAIT_W, 8, width of the memory wait counter.
WAIT_MAX, 200, cycles waited in FETCH or MEM without a hit before bus_err; must be < 2**WAIT_W.

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
instr  in  WORD_W  instruction word from icache; sampled only when ihit is high in FETCH
ihit  in  1  icache hit/ready
dhit  in  1  dcache hit/ready
zero  in  1  ALU zero flag, valid in EXEC
iREN  out  1  instruction read request
dREN  out  1  data read request
dWEN  out  1  data write request
pc_en  out  1  one-cycle PC update strobe
pc_src  out  2  0=PC+4, 1=branch target, 2=jump target, 3=register (JR)
reg_wen  out  1  register-file write enable
reg_dst  out  2  0=rt, 1=rd, 2=r31
wsel  out  2  writeback source: 0=ALU, 1=dmem, 2=PC+4, 3=LUI immediate
alu_op  out  aluop_t  ALU operation
alu_src  out  1  0=rt data, 1=extended immediate
ext_sel  out  1  0=zero-extend, 1=sign-extend
halt  out  1  sticky halt
bus_err  out  1  sticky wait-timeout error
illegal  out  1  one-cycle pulse in DECODE for an unknown opcode/funct
state_o  out  3  current state, for debug/trace

Behaviour:
- States: RST, FETCH, DECODE, EXEC, MEM, WB, HALT.
- nRST low puts the FSM in RST asynchronously and clears IR, the wait counter, halt and bus_err.
- All outputs are 0 in RST. RST always goes to FETCH on the next edge.
- FETCH:
  - iREN=1.
  - On ihit: latch instr into IR, clear the wait counter, go to DECODE.
  - Otherwise increment the wait counter.
- DECODE:
  - Drive alu_op, alu_src, ext_sel, reg_dst and wsel from IR. These hold through to the end of the instruction.
  - Opcode 0x3F goes to HALT.
  - Unknown opcode or unknown R-type funct pulses illegal; the instruction executes as a NOP (EXEC with pc_en, no writes).
  - Otherwise go to EXEC.
- EXEC:
  - BEQ/BNE: pc_src=1 if the condition holds (zero / !zero), else 0; assert pc_en; go to FETCH.
  - J: pc_src=2, pc_en, go to FETCH.
  - JR: pc_src=3, pc_en, go to FETCH.
  - LW/SW go to MEM. All others go to WB.
- MEM:
  - LW drives dREN=1; SW drives dWEN=1. The wait counter counts each cycle without dhit.
  - On dhit: LW goes to WB; SW asserts pc_en (pc_src=0) and goes to FETCH.
- WB:
  - reg_wen=1 and pc_en=1 for exactly one cycle.
  - JAL: reg_dst=2, wsel=2, pc_src=2. All others: pc_src=0.
  - Then go to FETCH.
- HALT: sticky until nRST. No requests and no enables; halt=1.
- Timeout: if the wait counter reaches WAIT_MAX in FETCH or MEM, set bus_err, deassert all requests and go to HALT (halt also=1).
- Counter behaviour: the counter saturates and never wraps. It clears on every state entry.
- iREN, dREN and dWEN are never high together. Requests stay held until the hit; they are never dropped mid-wait except on reset or timeout.
- Minimum latencies with hits in the first request cycle:
  - R-type/I-type ALU: 4 cycles.
  - LW: 5 cycles.
  - SW and branch/jump: 4 and 3 cycles respectively.
  - JAL: 4 cycles.
- Reset mid-MEM: dREN/dWEN drop in the same cycle nRST falls (combinational from state). A hit arriving during reset is ignored.

Decomposition:
- cpu_types_pkg (existing) holds opcode_t, funct_t, aluop_t and the field widths.
- Add to cpu_types_pkg: a mc_state_t enum and localparams PCSRC_*, WSEL_*, REGDST_*.
- Sub-module: instr_decoder, purely combinational, mapping IR to static control fields plus an illegal flag. The FSM wrapper owns IR, state, counter and the enables.

Test Plan:
- ADDU (0x00851021): ihit in cycle 1 → DECODE, EXEC, WB. reg_wen=1 and pc_en=1 only in WB; alu_op=ADDU, reg_dst=1; total 4 cycles.
- LW (0x8C820004): dhit delayed 3 cycles → dREN held high for exactly 4 MEM cycles, then WB with wsel=1; iREN=0 throughout MEM.
- BEQ (0x10850003): run with zero=1 → pc_src=1 and pc_en in EXEC, no reg_wen. Rerun with zero=0 → pc_src=0.
- JAL (0x0C000010) → WB asserts reg_dst=2, wsel=2, pc_src=2, reg_wen=1.
- ihit held low for WAIT_MAX=200 cycles → bus_err=1 and halt=1 on cycle 200, iREN=0 after; both stay set until nRST.
- HALT (0xFC000000) → halt stays 1 and no requests. Assert nRST low mid-MEM of a SW → dWEN drops immediately, state_o=RST, then FETCH on the cycle after release.
